// File: rtl/seq_checker_if.sv
// Bundle of the sequence-checker signals.
//   master : the side that drives samples (valid, state_in) and watches the results
//   slave  : the checker itself; takes samples and drives status/counters
// Signals:
//   valid      - state_in is meaningful this cycle
//   state_in   - observed 4-bit sequence value
//   locked     - checker is in TRACK or DONE
//   done       - checker is in DONE
//   err        - one-cycle pulse per violation
//   err_count  - saturating violation count
//   pass_count - wrapping count of completed runs
//   expected   - value required on the next valid sample
interface seq_checker_if;
   logic       valid;
   logic [3:0] state_in;
   logic       locked;
   logic       done;
   logic       err;
   logic [7:0] err_count;
   logic [7:0] pass_count;
   logic [3:0] expected;

   modport master (
      output valid, state_in,
      input  locked, done, err, err_count, pass_count, expected
   );

   modport slave (
      input  valid, state_in,
      output locked, done, err, err_count, pass_count, expected
   );
endinterface

// File: rtl/seq_checker.sv
// Monitors a 4-bit counting sequence START..LAST and reports lock, completion and
// violations. Every output is registered, so a sample shows its effect one cycle later.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-high; returns the checker to IDLE with cleared counters
//   bus   - seq_checker_if.slave: valid/state_in in; locked, done, err, err_count,
//           pass_count, expected out
module seq_checker #(
   parameter logic [3:0] START = 4'd0,
   parameter logic [3:0] LAST  = 4'd9
) (
   input logic          clk,
   input logic          reset,
   seq_checker_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StTrack, StDone, StFault} state_e;

   state_e     state_q;
   logic       locked_q;
   logic       done_q;
   logic       err_q;
   logic [7:0] err_count_q;
   logic [7:0] pass_count_q;
   logic [3:0] expected_q;

   logic [7:0] err_count_inc;
   assign err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         locked_q     <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_count_q  <= 8'd0;
         pass_count_q <= 8'd0;
         expected_q   <= START;
      end else begin
         // err is a pulse: cleared every cycle unless a violation is flagged below.
         err_q <= 1'b0;
         if (bus.valid) begin
            unique case (state_q)
               StIdle: begin
                  if (bus.state_in == START) begin
                     state_q    <= StTrack;
                     locked_q   <= 1'b1;
                     expected_q <= START + 4'd1;
                  end
               end
               StTrack: begin
                  if (bus.state_in == expected_q) begin
                     if (bus.state_in == LAST) begin
                        state_q      <= StDone;
                        done_q       <= 1'b1;
                        expected_q   <= LAST;
                        pass_count_q <= pass_count_q + 8'd1;
                     end else begin
                        expected_q <= expected_q + 4'd1;
                     end
                  end else begin
                     state_q     <= StFault;
                     locked_q    <= 1'b0;
                     err_q       <= 1'b1;
                     err_count_q <= err_count_inc;
                     expected_q  <= START;
                  end
               end
               StDone: begin
                  if (bus.state_in == LAST) begin
                     // Holding at the terminal value is legal.
                  end else if (bus.state_in == START) begin
                     state_q    <= StTrack;
                     done_q     <= 1'b0;
                     expected_q <= START + 4'd1;
                  end else begin
                     state_q     <= StFault;
                     locked_q    <= 1'b0;
                     done_q      <= 1'b0;
                     err_q       <= 1'b1;
                     err_count_q <= err_count_inc;
                     expected_q  <= START;
                  end
               end
               StFault: begin
                  // Only START leaves FAULT; anything else is silent so a fault
                  // episode yields a single err pulse.
                  if (bus.state_in == START) begin
                     state_q    <= StTrack;
                     locked_q   <= 1'b1;
                     expected_q <= START + 4'd1;
                  end
               end
               default: begin
                  state_q    <= StIdle;
                  locked_q   <= 1'b0;
                  done_q     <= 1'b0;
                  expected_q <= START;
               end
            endcase
         end
      end
   end

   assign bus.locked     = locked_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.err_count  = err_count_q;
   assign bus.pass_count = pass_count_q;
   assign bus.expected   = expected_q;

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;

   logic clk;
   logic reset;

   seq_checker_if bus ();

   seq_checker #(
      .START(4'd0),
      .LAST (4'd9)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [3:0] s;
      logic       lk;
      logic       dn;
      logic       er;
      logic [7:0] ec;
      logic [7:0] pc;
      logic [3:0] ex;
   } vec_t;

   vec_t vecs[$];
   int   n_total;
   int   n_pass;

   function automatic void add(input logic v, input logic [3:0] s, input logic lk,
                               input logic dn, input logic er, input logic [7:0] ec,
                               input logic [7:0] pc, input logic [3:0] ex);
      vec_t r;
      r.v = v; r.s = s; r.lk = lk; r.dn = dn; r.er = er; r.ec = ec; r.pc = pc; r.ex = ex;
      vecs.push_back(r);
   endfunction

   // A complete 0..9 run starting from IDLE/DONE/FAULT with given counters.
   function automatic void add_run(input logic [7:0] pc0, input logic [7:0] ec);
      for (int i = 0; i < 10; i++) begin
         if (i == 9) add(1'b1, 4'(i), 1'b1, 1'b1, 1'b0, ec, pc0 + 8'd1, 4'd9);
         else        add(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, ec, pc0, 4'(i + 1));
      end
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act,
                      input logic [7:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s[%0d]: got %0d, want %0d", nm, idx, act, req);
   endtask

   task automatic chk_all(input string nm, input int idx, input logic lk, input logic dn,
                          input logic er, input logic [7:0] ec, input logic [7:0] pc,
                          input logic [3:0] ex);
      chk({nm, ".locked"}, idx, {7'd0, bus.locked}, {7'd0, lk});
      chk({nm, ".done"}, idx, {7'd0, bus.done}, {7'd0, dn});
      chk({nm, ".err"}, idx, {7'd0, bus.err}, {7'd0, er});
      chk({nm, ".err_count"}, idx, bus.err_count, ec);
      chk({nm, ".pass_count"}, idx, bus.pass_count, pc);
      chk({nm, ".expected"}, idx, {4'd0, bus.expected}, {4'd0, ex});
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic apply(input logic v, input logic [3:0] s);
      @(negedge clk);
      bus.valid    = v;
      bus.state_in = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      bus.valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      n_total      = 0;
      n_pass       = 0;
      reset        = 1'b1;
      bus.valid    = 1'b0;
      bus.state_in = 4'd0;

      // ---------------- vector table ----------------
      add(1, 5, 0, 0, 0, 0, 0, 0);                 // IDLE ignores non-START
      add_run(8'd0, 8'd0);                         // clean run, pc=1
      add(1, 9, 1, 1, 0, 0, 1, 9);                 // hold at LAST
      add(1, 9, 1, 1, 0, 0, 1, 9);
      for (int i = 0; i < 8; i++) add(1, 4'(i), 1, 0, 0, 0, 1, 4'(i + 1));
      add(1, 0, 0, 0, 1, 1, 1, 0);                 // 7 -> 0 skip: fault
      add(1, 1, 0, 0, 0, 1, 1, 0);                 // stays FAULT, no second err
      add_run(8'd1, 8'd1);                         // recovery
      add_run(8'd2, 8'd1);                         // restart from DONE
      add(1, 0, 1, 0, 0, 1, 3, 1);                 // gaps
      add(1, 1, 1, 0, 0, 1, 3, 2);
      add(0, 13, 1, 0, 0, 1, 3, 2);
      add(0, 5, 1, 0, 0, 1, 3, 2);
      add(0, 0, 1, 0, 0, 1, 3, 2);
      add(0, 9, 1, 0, 0, 1, 3, 2);
      add(0, 15, 1, 0, 0, 1, 3, 2);
      add(1, 2, 1, 0, 0, 1, 3, 3);
      add(1, 15, 0, 0, 1, 2, 3, 0);                // out of range
      add(0, 0, 0, 0, 0, 2, 3, 0);                 // idle cycle clears err
      add_run(8'd3, 8'd2);                         // pc=4
      add(1, 3, 0, 0, 1, 3, 4, 0);                 // illegal value from DONE
      add(1, 3, 0, 0, 0, 3, 4, 0);

      // ---------------- reset state ----------------
      #12;
      chk_all("reset", 0, 0, 0, 0, 8'd0, 8'd0, 4'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         apply(vecs[i].v, vecs[i].s);
         chk_all("vec", i, vecs[i].lk, vecs[i].dn, vecs[i].er, vecs[i].ec, vecs[i].pc,
                 vecs[i].ex);
      end

      // ---------------- async reset mid-run ----------------
      for (int i = 0; i < 5; i++) apply(1'b1, 4'(i));
      chk_all("pre_areset", 0, 1, 0, 0, 8'd3, 8'd4, 4'd5);
      #2;
      reset = 1'b1;                                // between edges
      #1;
      chk_all("areset", 0, 0, 0, 0, 8'd0, 8'd0, 4'd0);
      @(negedge clk);
      reset = 1'b0;
      apply(1'b1, 4'd5);
      chk_all("post_areset5", 0, 0, 0, 0, 8'd0, 8'd0, 4'd0);
      apply(1'b1, 4'd0);
      chk_all("post_areset0", 0, 1, 0, 0, 8'd0, 8'd0, 4'd1);

      // ---------------- err_count saturation ----------------
      do_reset();
      for (int k = 1; k <= 256; k++) begin
         apply(1'b1, 4'd0);
         apply(1'b1, 4'd3);
         chk("sat.err", k, {7'd0, bus.err}, 8'd1);
         if (k == 1 || k == 255 || k == 256)
            chk("sat.err_count", k, bus.err_count, (k == 1) ? 8'd1 : 8'd255);
      end

      // ---------------- pass_count wrap ----------------
      do_reset();
      for (int r = 1; r <= 256; r++) begin
         for (int i = 0; i < 10; i++) apply(1'b1, 4'(i));
         if (r == 1 || r == 255 || r == 256)
            chk("wrap.pass_count", r, bus.pass_count, 8'(r));
      end
      chk("wrap.done", 256, {7'd0, bus.done}, 8'd1);
      chk("wrap.err_count", 256, bus.err_count, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
